// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin scheduler that shares one AXI-Stream sink
// among NUM_PORTS requesters. A grant lasts for one packet or at most
// MAX_BURST beats. While a grant is held, the granted stream is forwarded
// combinationally to the sink. There is always a one-cycle IDLE bubble
// between grants.
// Optional build macro: AXIS_ARB_PKT_LOCK_EN. When it is defined, a grant
// is released only on the tlast beat, so packets are never interleaved.
module axis_rr_arbiter #(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 8,
  localparam int IDW        = $clog2(NUM_PORTS)
) (
  input  logic                            axis_clk,
  input  logic                            axis_rst,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            grant_valid,
  output logic [IDW-1:0]                  grant_id
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         r_state;
  logic           r_grant_valid;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_last_grant;
  logic [7:0]     r_beat_cnt;

  logic                  w_busy;
  logic                  w_any;
  logic [IDW-1:0]        w_next;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_beat;
  logic                  w_release;

  assign w_busy = (r_state == BUSY);

  // Rotating priority search. It starts one past the last granted port
  // and wraps around, so the previous winner has the lowest priority.
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_next = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_PORTS;
      if (!w_any && s_axis_tvalid[idx]) begin
        w_any  = 1'b1;
        w_next = IDW'(idx);
      end
    end
  end

  // Select the granted port's stream for forwarding.
  always_comb begin
    w_sel_valid = s_axis_tvalid[r_grant_id];
    w_sel_last  = s_axis_tlast[r_grant_id];
    w_sel_data  = s_axis_tdata[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_beat = w_busy && w_sel_valid && m_axis_tready;

`ifdef AXIS_ARB_PKT_LOCK_EN
  // The grant is held until the packet ends; beat_cnt just wraps.
  assign w_release = w_beat && w_sel_last;
`else
  // The grant is released at the packet end or when the burst cap is
  // reached, whichever comes first.
  assign w_release = w_beat &&
                     (w_sel_last || (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BURST)));
`endif

  // Zero-latency forwarding. IDLE never forwards, and the outputs stay at
  // zero outside a grant.
  assign m_axis_tvalid = w_busy && w_sel_valid;
  assign m_axis_tdata  = w_busy ? w_sel_data : '0;
  assign m_axis_tlast  = w_busy && w_sel_last;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;

  // Ready depends only on state, grant_id and sink ready. It never
  // depends on tvalid, so no combinational loop forms through the requester.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdy
    assign s_axis_tready[i] = w_busy && (r_grant_id == IDW'(i)) && m_axis_tready;
  end

  // Grant FSM: arbitrate in IDLE, count beats in BUSY, release to IDLE.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state       <= IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_beat_cnt    <= '0;
      r_last_grant  <= IDW'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state       <= BUSY;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_next;
            r_beat_cnt    <= '0;
          end
        end
        BUSY: begin
          if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
          if (w_release) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_last_grant  <= r_grant_id;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter. Per-port source queues model
// the AXIS requesters. Expected sink beats go to a scoreboard queue when a
// test loads its stimulus, and they are compared as beats appear at the sink.
module tb_axis_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int MB = 8;
`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic             axis_clk = 1'b0;
  logic             axis_rst = 1'b1;
  logic [NP-1:0]    s_axis_tvalid = '0;
  logic [NP-1:0]    s_axis_tready;
  logic [NP*DW-1:0] s_axis_tdata = '0;
  logic [NP-1:0]    s_axis_tlast = '0;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tlast;
  logic             grant_valid;
  logic [1:0]       grant_id;

  always #5 axis_clk = ~axis_clk;

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    gid;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] src_q[NP][$];   // {tlast, tdata}
  int          n_cmp = 0;
  int          n_err = 0;
  int          mon_beats = 0;
  bit          rel_exp = 1'b0;

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    logic [32:0] h;
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() != 0) begin
        h = src_q[i][0];
        s_axis_tvalid[i]             = 1'b1;
        s_axis_tlast[i]              = h[32];
        s_axis_tdata[i*DW +: DW]     = h[31:0];
      end else begin
        s_axis_tvalid[i]             = 1'b0;
        s_axis_tlast[i]              = 1'b0;
        s_axis_tdata[i*DW +: DW]     = '0;
      end
    end
  endtask

  task automatic load(input int port, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[port].push_back({(k == n-1), base + 32'(k)});
  endtask

  task automatic expect_beats(input int port, input logic [31:0] base,
                              input int first, input int cnt, input int pkt_len);
    exp_t e;
    for (int k = first; k < first + cnt; k++) begin
      e.data = base + 32'(k);
      e.last = (k == pkt_len - 1);
      e.gid  = 2'(port);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    mon_beats = 0;
    rel_exp   = 1'b0;
  endtask

  // One clock. At the negedge it checks the sink, the readies and the
  // bubble; after the posedge it retires the source beats that handshook.
  task automatic cycle();
    logic [NP-1:0] hs;
    logic [NP-1:0] er;
    exp_t e;
    @(negedge axis_clk);
    if (rel_exp) begin
      n_cmp++;
      if (grant_valid !== 1'b0) begin
        n_err++; $display("FAIL bubble: grant_valid=%0b required 0", grant_valid);
      end
    end
    rel_exp = 1'b0;
    er = (grant_valid && m_axis_tready) ? (NP'(1) << grant_id) : '0;
    n_cmp++;
    if (s_axis_tready !== er) begin
      n_err++; $display("FAIL tready_mask: got %b required %b", s_axis_tready, er);
    end
    if (!grant_valid) begin
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
        n_err++; $display("FAIL idle_fwd: tvalid=%0b tlast=%0b tdata=%h required zeros",
                          m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
    end else begin
      n_cmp++;
      if (m_axis_tvalid !== s_axis_tvalid[grant_id]) begin
        n_err++; $display("FAIL fwd_valid: got %0b required %0b",
                          m_axis_tvalid, s_axis_tvalid[grant_id]);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL extra_beat: got data=%h gid=%0d, required none",
                          m_axis_tdata, grant_id);
      end else begin
        e = exp_q.pop_front();
        if ({m_axis_tdata, m_axis_tlast, grant_id} !== {e.data, e.last, e.gid}) begin
          n_err++; $display("FAIL beat: got data=%h last=%0b gid=%0d required data=%h last=%0b gid=%0d",
                            m_axis_tdata, m_axis_tlast, grant_id, e.data, e.last, e.gid);
        end
      end
      mon_beats++;
      if (m_axis_tlast || (!LOCK && mon_beats == MB)) begin
        rel_exp   = 1'b1;
        mon_beats = 0;
      end
    end
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge axis_clk);
    #1;
    for (int i = 0; i < NP; i++) if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input int maxc, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || src_busy()) && c < maxc) begin
      cycle();
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || src_busy()) begin
      n_err++; $display("FAIL %s_timeout: %0d expected beats left after %0d cycles, required 0",
                        name, exp_q.size(), maxc);
    end
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    axis_rst      = 1'b1;
    m_axis_tready = 1'b1;
    flush();
    drive();
    repeat (2) @(posedge axis_clk);
    #1;
    n_cmp++;
    if ({grant_valid, grant_id, m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready} !== '0) begin
      n_err++; $display("FAIL reset_state: gv=%0b gid=%0d mv=%0b ml=%0b md=%h rdy=%b required all 0",
                        grant_valid, grant_id, m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
    end
    axis_rst = 1'b0;
  endtask

  task automatic test_two_ports();
    test_reset();
    load(0, 32'hA0, 3);
    load(2, 32'hC0, 3);
    expect_beats(0, 32'hA0, 0, 3, 3);
    expect_beats(2, 32'hC0, 0, 3, 3);
    drive();
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_err++; $display("FAIL arb_latency: gv=%0b before first edge, required 0", grant_valid);
    end
    cycle();
    n_cmp++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0}) begin
      n_err++; $display("FAIL first_grant: gv=%0b gid=%0d required gv=1 gid=0", grant_valid, grant_id);
    end
    run_until_empty(40, "two_ports");
  endtask

  task automatic test_rr_all();
    test_reset();
    for (int i = 0; i < NP; i++) begin
      load(i, 32'h1000 + 32'(i*16), 1);
      load(i, 32'h1000 + 32'(i*16) + 32'h8, 1);
    end
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NP; i++)
        expect_beats(i, 32'h1000 + 32'(i*16) + 32'(n*8), 0, 1, 1);
    drive();
    run_until_empty(60, "rr_all");
  endtask

  task automatic test_burst();
    test_reset();
    load(1, 32'h100, 20);
    load(3, 32'h300, 4);
    if (LOCK) begin
      expect_beats(1, 32'h100, 0, 20, 20);
      expect_beats(3, 32'h300, 0, 4, 4);
    end else begin
      expect_beats(1, 32'h100, 0, 8, 20);
      expect_beats(3, 32'h300, 0, 4, 4);
      expect_beats(1, 32'h100, 8, 8, 20);
      expect_beats(1, 32'h100, 16, 4, 20);
    end
    drive();
    run_until_empty(100, "burst");
  endtask

  task automatic test_stall();
    test_reset();
    load(0, 32'h50, 6);
    expect_beats(0, 32'h50, 0, 6, 6);
    drive();
    repeat (3) cycle();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_cmp++;
      if ({s_axis_tready[0], m_axis_tvalid, m_axis_tdata} !== {1'b0, 1'b1, 32'h52}) begin
        n_err++; $display("FAIL stall_hold: rdy0=%0b mv=%0b md=%h required rdy0=0 mv=1 md=00000052",
                          s_axis_tready[0], m_axis_tvalid, m_axis_tdata);
      end
    end
    m_axis_tready = 1'b1;
    run_until_empty(40, "stall");
  endtask

  task automatic test_reset_mid();
    int c = 0;
    test_reset();
    load(2, 32'h60, 6);
    expect_beats(2, 32'h60, 0, 6, 6);
    drive();
    while (exp_q.size() > 2 && c < 20) begin
      cycle();
      c++;
    end
    axis_rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant_valid, m_axis_tvalid, s_axis_tready} !== '0) begin
      n_err++; $display("FAIL rst_mid: gv=%0b mv=%0b rdy=%b required all 0",
                        grant_valid, m_axis_tvalid, s_axis_tready);
    end
    flush();
    load(1, 32'h71, 1);
    load(2, 32'h72, 1);
    load(3, 32'h73, 1);
    expect_beats(1, 32'h71, 0, 1, 1);
    expect_beats(2, 32'h72, 0, 1, 1);
    expect_beats(3, 32'h73, 0, 1, 1);
    drive();
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst = 1'b0;
    cycle();
    n_cmp++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL post_rst_grant: gv=%0b gid=%0d required gv=1 gid=1", grant_valid, grant_id);
    end
    run_until_empty(40, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_two_ports();
    test_rr_all();
    test_burst();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
